// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Width of a counter holding 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared add/subtract unit: sel=1 adds, sel=0 subtracts (a - b).
module alu #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? (a + b) : (a - b);

endmodule

// File: rtl/muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer around the shared alu.
// Optional signed support is built when MULDIV_SIGNED_EN is defined.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [PW-1:0]    p_reg;
  logic [PW-1:0]    p_next;
  logic [PW-1:0]    shifted;
  logic [PW-1:0]    alu_a;
  logic [PW-1:0]    alu_b;
  logic [PW-1:0]    alu_y;
  logic             alu_sel;
  logic [CW-1:0]    count_reg;
  logic             op_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;
  logic [PW-1:WIDTH+1] unused_alu_bits;

  alu #(.WIDTH(PW)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .y   (alu_y)
  );

  assign unused_alu_bits = alu_y[PW-1:WIDTH+1];

  // One iteration: multiply adds the multiplicand into the upper part then
  // shifts right; divide shifts left and keeps the trial difference if it
  // did not go negative.
  always_comb begin
    shifted = {p_reg[PW-2:0], 1'b0};
    alu_sel = (op_reg == OP_MUL);
    alu_a   = alu_sel ? PW'(p_reg[PW-1:WIDTH]) : PW'(shifted[PW-1:WIDTH]);
    alu_b   = PW'(opnd_reg);
    p_next  = shifted;
    if (alu_sel) begin
      p_next = {1'b0, (p_reg[0] ? alu_y[WIDTH:0] : p_reg[PW-1:WIDTH]), p_reg[WIDTH-1:1]};
    end else if (!alu_y[WIDTH]) begin
      p_next = {alu_y[WIDTH:0], shifted[WIDTH-1:0]} | PW'(1);
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic             neg_res_reg;
  logic             neg_rem_reg;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
    prod  = p_next[2*WIDTH-1:0];
    if (op_reg == OP_MUL) begin
      {fin_hi, fin_lo} = neg_res_reg ? -prod : prod;
    end else begin
      fin_lo = neg_res_reg ? -p_next[WIDTH-1:0] : p_next[WIDTH-1:0];
      fin_hi = neg_rem_reg ? -p_next[2*WIDTH-1:WIDTH] : p_next[2*WIDTH-1:WIDTH];
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_op;
  assign a_mag  = a;
  assign b_mag  = b;
  assign fin_hi = p_next[2*WIDTH-1:WIDTH];
  assign fin_lo = p_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      p_reg       <= '0;
      count_reg   <= '0;
      op_reg      <= OP_MUL;
      opnd_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        RUN: begin
          p_reg     <= p_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_hi <= fin_hi;
            result_lo <= fin_lo;
          end
        end
        default: begin
          state_reg <= IDLE;
          if (start) begin
            op_reg      <= op;
            count_reg   <= '0;
            div_by_zero <= 1'b0;
            if (op == OP_DIV && b == '0) begin
              // Divide by zero skips iteration entirely.
              state_reg   <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result_hi   <= a;
              result_lo   <= '1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
              p_reg     <= PW'((op == OP_MUL) ? b_mag : a_mag);
              opnd_reg  <= (op == OP_MUL) ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
              neg_res_reg <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_reg <= signed_op && a[WIDTH-1];
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
